mod3_result_collector: RTL

- Downstream consumer of the serial 32/64-bit mod-3 engine (ports s, f, i).
- Detects each completion (rising edge of f) and captures the residue s with the step index i.
- Buffers captures in a small show-ahead FIFO with a valid/ready output handshake.
- Keeps per-residue statistics and sticky error/overflow flags for the lab bench and the display logic.

---
 rtl/mod3_result_collector_if.sv | 15 +
 rtl/mod3_result_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod3_result_collector_if.sv
// Output handshake bundle of the mod-3 result collector.
//   out_valid : FIFO head is valid            (collector -> consumer)
//   out_ready : consumer accepts the head     (consumer  -> collector)
//   out_data  : {step index, residue}, residue in the two LSBs
// The master modport is the collector side, the slave modport the consumer side.
interface mod3_result_collector_if #(
    parameter int IDX_W = 8
) ();
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W+1:0]   out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/mod3_result_collector.sv
// Collector sitting behind the serial mod-3 engine.
// Each rising edge of the engine finish flag captures {i_in, s_in} into a
// small show-ahead FIFO that is drained through a valid/ready handshake.
// Per-residue counters, a drop counter and sticky overflow/error flags are
// kept for the lab bench and the display logic.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   s_in, f_in, i_in: engine residue, finish flag (level), step index
//   clr             : synchronous clear of counters and sticky flags
//   out_if          : valid/ready/data of the FIFO head (master side)
//   cnt0..cnt2      : accepted results per residue (saturating)
//   drop_cnt        : captures lost on a full FIFO (saturating)
//   ovf, err        : sticky drop flag, sticky illegal-residue flag
//   level           : FIFO occupancy 0..DEPTH
module mod3_result_collector #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1,
    localparam int DW    = IDX_W + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              s_in,
    input  logic                    f_in,
    input  logic [IDX_W-1:0]        i_in,
    input  logic                    clr,
    mod3_result_collector_if.master out_if,
    output logic [CNT_W-1:0]        cnt0,
    output logic [CNT_W-1:0]        cnt1,
    output logic [CNT_W-1:0]        cnt2,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    ovf,
    output logic                    err,
    output logic [LVL_W-1:0]        level
);

    // Saturating increment used by all statistic counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    logic               f_q, f_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [DW-1:0]      mem_d [DEPTH];
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic [CNT_W-1:0]   cnt2_q, cnt2_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic               cap_s;
    logic               legal_s;
    logic               full_s;
    logic               empty_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;

    // Event decode: capture on finish rise, pop on handshake, push/drop on legal capture.
    always_comb begin
        cap_s   = f_in & ~f_q;
        legal_s = (s_in != 2'd3);
        full_s  = (level_q == LVL_W'(DEPTH));
        empty_s = (level_q == {LVL_W{1'b0}});
        pop_s   = ~empty_s & out_if.out_ready;
        // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
        push_s  = cap_s & legal_s & (~full_s | pop_s);
        drop_s  = cap_s & legal_s & full_s & ~pop_s;
    end

    // Show-ahead head: data is driven straight from the head entry, zero when empty.
    always_comb begin
        out_if.out_valid = ~empty_s;
        out_if.out_data  = {DW{1'b0}};
        if (!empty_s) begin
            out_if.out_data = mem_q[rd_ptr_q];
        end else begin
            out_if.out_data = {DW{1'b0}};
        end
    end

    // FIFO next state: storage, pointers (wrap naturally modulo DEPTH) and occupancy.
    always_comb begin
        f_d      = f_in;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {i_in, s_in};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1'b1);
            2'b01:   level_d = level_q - LVL_W'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Statistics next state; clr overrides any update from a same-cycle capture.
    always_comb begin
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        if (clr) begin
            cnt0_d     = {CNT_W{1'b0}};
            cnt1_d     = {CNT_W{1'b0}};
            cnt2_d     = {CNT_W{1'b0}};
            drop_cnt_d = {CNT_W{1'b0}};
            ovf_d      = 1'b0;
            err_d      = 1'b0;
        end else begin
            if (push_s) begin
                case (s_in)
                    2'd0:    cnt0_d = sat_inc(cnt0_q);
                    2'd1:    cnt1_d = sat_inc(cnt1_q);
                    2'd2:    cnt2_d = sat_inc(cnt2_q);
                    default: cnt0_d = cnt0_q;
                endcase
            end else begin
                cnt0_d = cnt0_q;
            end
            if (drop_s) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
                ovf_d      = 1'b1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (cap_s && !legal_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q        <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            cnt0_q     <= {CNT_W{1'b0}};
            cnt1_q     <= {CNT_W{1'b0}};
            cnt2_q     <= {CNT_W{1'b0}};
            drop_cnt_q <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {DW{1'b0}};
            end
        end else begin
            f_q        <= f_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;
    assign cnt2     = cnt2_q;
    assign drop_cnt = drop_cnt_q;
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign level    = level_q;

endmodule
